// File: rtl/demux_pkg.sv
// Shared constants and the channel state type for the registered 1-to-4 demultiplexer.
package demux_pkg;
  localparam int NUM_CANAIS       = 4;
  localparam int DESTINO_LARGURA  = 2;
  localparam int CONTADOR_LARGURA = 8;

  typedef enum logic {
    VAZIO = 1'b0,
    CHEIO = 1'b1
  } estado_t;
endpackage

// File: rtl/demux_canal.sv
// One-entry output buffer for a single demux channel.
// Optional feature: DEMUX_CONTADOR_EN adds a wrapping 8-bit delivery counter.
module demux_canal
  import demux_pkg::*;
#(
  parameter int LARGURA = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        carga_i,
  input  logic [LARGURA-1:0]          dado_i,
  input  logic                        pronta_i,
  output logic                        livre_o,
  output logic [LARGURA-1:0]          dado_o,
`ifdef DEMUX_CONTADOR_EN
  output logic [CONTADOR_LARGURA-1:0] contagem_o,
`endif
  output estado_t                     estado_o
);

  estado_t            estado_q, estado_d;
  logic [LARGURA-1:0] dado_q;
  logic               entrega;

  assign entrega  = (estado_q == CHEIO) && pronta_i;
  // A full buffer can still take a word in the same cycle it is drained.
  assign livre_o  = (estado_q == VAZIO) || pronta_i;
  assign dado_o   = dado_q;
  assign estado_o = estado_q;

  always_comb begin
    estado_d = estado_q;
    if (carga_i) begin
      estado_d = CHEIO;
    end else if (entrega) begin
      estado_d = VAZIO;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= VAZIO;
      dado_q   <= '0;
    end else begin
      estado_q <= estado_d;
      if (carga_i) begin
        dado_q <= dado_i;
      end
    end
  end

`ifdef DEMUX_CONTADOR_EN
  logic [CONTADOR_LARGURA-1:0] contagem_q;

  assign contagem_o = contagem_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contagem_q <= '0;
    end else if (entrega) begin
      contagem_q <= contagem_q + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/demux_registrado.sv
// Registered 1-to-4 demultiplexer with valid/ready on the input and on each channel.
// Optional feature: DEMUX_CONTADOR_EN exposes per-channel delivery counters on contagem.
module demux_registrado
  import demux_pkg::*;
#(
  parameter int LARGURA = 2
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic [LARGURA-1:0]                           entrada,
  input  logic [DESTINO_LARGURA-1:0]                   destino,
  input  logic                                         entrada_valida,
  output logic                                         entrada_pronta,
  output logic [NUM_CANAIS-1:0][LARGURA-1:0]           saida,
  output logic [NUM_CANAIS-1:0]                        saida_valida,
`ifdef DEMUX_CONTADOR_EN
  output logic [NUM_CANAIS-1:0][CONTADOR_LARGURA-1:0]  contagem,
`endif
  input  logic [NUM_CANAIS-1:0]                        saida_pronta
);

  // Handshake: a word moves on a rising edge where valid and ready are both 1;
  // ready never looks at valid, and valid holds its word until it moves.
  logic [NUM_CANAIS-1:0] livre;
  logic [NUM_CANAIS-1:0] carga;
  estado_t               estado [NUM_CANAIS];

  assign entrada_pronta = livre[destino];

  always_comb begin
    carga = '0;
    carga[destino] = entrada_valida && entrada_pronta;
  end

  for (genvar k = 0; k < NUM_CANAIS; k++) begin : g_canal
    demux_canal #(
      .LARGURA (LARGURA)
    ) u_canal (
      .clock      (clock),
      .reset      (reset),
      .carga_i    (carga[k]),
      .dado_i     (entrada),
      .pronta_i   (saida_pronta[k]),
      .livre_o    (livre[k]),
      .dado_o     (saida[k]),
`ifdef DEMUX_CONTADOR_EN
      .contagem_o (contagem[k]),
`endif
      .estado_o   (estado[k])
    );

    assign saida_valida[k] = (estado[k] == CHEIO);
  end

endmodule

// File: tb/tb_demux_registrado.sv
// Directed bench for demux_registrado; build with +define+DEMUX_CONTADOR_EN to cover the counters.
module tb_demux_registrado;
  localparam int LARGURA = 2;

  logic                    clock;
  logic                    reset;
  logic [LARGURA-1:0]      entrada;
  logic [1:0]              destino;
  logic                    entrada_valida;
  logic                    entrada_pronta;
  logic [3:0][LARGURA-1:0] saida;
  logic [3:0]              saida_valida;
  logic [3:0]              saida_pronta;
`ifdef DEMUX_CONTADOR_EN
  logic [3:0][7:0]         contagem;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [LARGURA-1:0] exp_q[$];

  demux_registrado #(
    .LARGURA (LARGURA)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .entrada        (entrada),
    .destino        (destino),
    .entrada_valida (entrada_valida),
    .entrada_pronta (entrada_pronta),
    .saida          (saida),
    .saida_valida   (saida_valida),
`ifdef DEMUX_CONTADOR_EN
    .contagem       (contagem),
`endif
    .saida_pronta   (saida_pronta)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic send(input logic [LARGURA-1:0] d, input logic [1:0] dst);
    entrada        = d;
    destino        = dst;
    entrada_valida = 1'b1;
  endtask

  task automatic idle();
    entrada_valida = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset          = 1'b1;
    entrada        = '0;
    destino        = '0;
    entrada_valida = 1'b0;
    saida_pronta   = 4'b0000;
    tick();
    #1;
    check("reset_valida", 32'(saida_valida), 32'h0);
    check("reset_saida", 32'(saida), 32'h0);
    check("reset_pronta", 32'(entrada_pronta), 32'h1);
`ifdef DEMUX_CONTADOR_EN
    check("reset_contagem", contagem, 32'h0);
`endif
    @(negedge clock);
    reset = 1'b0;

    // Basic route: 11 to channel 1, then a blocked second word
    send(2'b11, 2'd1);
    #1 check("basic_pronta", 32'(entrada_pronta), 32'h1);
    tick();
    check("basic_valida", 32'(saida_valida), 32'h2);
    check("basic_saida1", 32'(saida[1]), 32'h3);
    send(2'b10, 2'd1);
    #1 check("basic_full_pronta", 32'(entrada_pronta), 32'h0);
    tick();
    check("basic_hold_saida1", 32'(saida[1]), 32'h3);
    check("basic_hold_valida", 32'(saida_valida), 32'h2);
    idle();
    saida_pronta = 4'b0010;
    tick();
    check("basic_drain", 32'(saida_valida), 32'h0);
    saida_pronta = 4'b0000;

    // Back-to-back on channel 3 with its consumer always ready
    saida_pronta = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      send(LARGURA'(i), 2'd3);
      exp_q.push_back(LARGURA'(i));
      #1 check("b2b_pronta", 32'(entrada_pronta), 32'h1);
      tick();
      check("b2b_valida3", 32'(saida_valida[3]), 32'h1);
      check("b2b_saida3", 32'(saida[3]), 32'(exp_q.pop_front()));
    end
    idle();
    tick();
    check("b2b_drain", 32'(saida_valida), 32'h0);
    saida_pronta = 4'b0000;

    // Independence: channel 0 stalled full, channel 2 still flows
    send(2'b01, 2'd0);
    tick();
    check("ind_fill0", 32'(saida_valida), 32'h1);
    send(2'b10, 2'd2);
    #1 check("ind_pronta2", 32'(entrada_pronta), 32'h1);
    tick();
    check("ind_saida2", 32'(saida[2]), 32'h2);
    check("ind_valida", 32'(saida_valida), 32'h5);
    check("ind_saida0", 32'(saida[0]), 32'h1);
    idle();
    destino = 2'd0;
    #1 check("ind_pronta0_stalled", 32'(entrada_pronta), 32'h0);
    saida_pronta = 4'b0101;
    #1 check("ind_pronta0_draining", 32'(entrada_pronta), 32'h1);
    tick();
    check("ind_drain", 32'(saida_valida), 32'h0);
    saida_pronta = 4'b0000;

    // Simultaneous drain and fill on channel 1
    send(2'b01, 2'd1);
    tick();
    check("sim_fill", 32'(saida[1]), 32'h1);
    saida_pronta = 4'b0010;
    send(2'b10, 2'd1);
    #1 check("sim_pronta", 32'(entrada_pronta), 32'h1);
    tick();
    check("sim_saida1", 32'(saida[1]), 32'h2);
    check("sim_valida", 32'(saida_valida), 32'h2);
    idle();
    tick();
    check("sim_drain", 32'(saida_valida), 32'h0);
    saida_pronta = 4'b0000;

    // Asynchronous reset with channel 2 full, then first transfer after release
    send(2'b11, 2'd2);
    tick();
    idle();
    check("rst_pre_valida", 32'(saida_valida), 32'h4);
    #2 reset = 1'b1;
    #1;
    check("rst_async_valida", 32'(saida_valida), 32'h0);
    check("rst_async_saida", 32'(saida), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    send(2'b01, 2'd2);
    tick();
    check("rst_first_valida", 32'(saida_valida), 32'h4);
    check("rst_first_saida2", 32'(saida[2]), 32'h1);
    idle();

`ifdef DEMUX_CONTADOR_EN
    // 257 deliveries on channel 0 wrap its counter to 1
    saida_pronta = 4'b0001;
    for (int i = 0; i < 257; i++) begin
      send(LARGURA'(i), 2'd0);
      tick();
    end
    idle();
    tick();
    saida_pronta = 4'b0000;
    check("cnt_ch0", 32'(contagem[0]), 32'h1);
    check("cnt_ch1", 32'(contagem[1]), 32'h0);
    check("cnt_ch2", 32'(contagem[2]), 32'h0);
    check("cnt_ch3", 32'(contagem[3]), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demux_registrado.md
DEMUX_REGISTRADO -- requirements
Module: demux_registrado

Interface
REQ-001 Parameter: LARGURA, default 2, data word width in bits.
REQ-002 Parameter: NUM_CANAIS, fixed 4, number of output channels, addressed by the 2-bit destino.
REQ-003 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: entrada  input  LARGURA  data word to route.
REQ-006 Port: destino  input  2  target channel index, 0..3.
REQ-007 Port: entrada_valida  input  1  producer offers entrada/destino this cycle.
REQ-008 Port: entrada_pronta  output  1  block accepts the offered word this cycle.
REQ-009 Port: saida  output  4xLARGURA  per-channel registered data.
REQ-010 Port: saida_valida  output  4  per-channel data-valid.
REQ-011 Port: saida_pronta  input  4  per-channel consumer ready.

Function
REQ-012 Each channel SHALL hold a one-entry buffer with states VAZIO and CHEIO.
REQ-013 Input transfer: entrada_valida=1 and entrada_pronta=1 at a rising edge.
REQ-014 Output transfer on channel k: saida_valida[k]=1 and saida_pronta[k]=1 at a rising edge.
REQ-015 entrada_pronta SHALL be combinational: channel destino is VAZIO, or saida_pronta[destino]=1.
REQ-016 entrada_pronta SHALL NOT depend on entrada_valida.
REQ-017 An input transfer SHALL load entrada into saida[destino] and set that channel CHEIO, visible the next cycle (latency 1).
REQ-018 VAZIO->CHEIO on an input transfer to k; CHEIO->VAZIO on an output transfer with no input transfer to k; otherwise the state is held.
REQ-019 Simultaneous output and input transfer on the same channel SHALL leave it CHEIO with the new word, with no bubble and no loss.
REQ-020 saida_valida[k] SHALL equal (state of k == CHEIO).
REQ-021 A CHEIO channel SHALL keep saida[k] stable until its output transfer.
REQ-022 Channels SHALL be independent: a stalled channel SHALL NOT block transfers to other channels.
REQ-023 Routing SHALL be order-preserving per channel; there is no reordering within a channel.
REQ-024 saida[k] of a VAZIO channel SHALL hold its last value; its content is don't-care.

Reset
REQ-025 While reset=1, every channel SHALL be VAZIO, saida SHALL be all zeros, and saida_valida SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL discard buffered words immediately, without waiting for a clock edge.
REQ-027 The first transfer after deassertion SHALL be accepted at the first rising edge with reset=0.

Configuration
REQ-028 The macro DEMUX_CONTADOR_EN SHALL control per-channel delivery counters.
REQ-029 With DEMUX_CONTADOR_EN defined: add output port contagem (4x8 bits). Each channel's counter SHALL increment on its output transfer, wrap 255->0, and reset to 0.
REQ-030 Without DEMUX_CONTADOR_EN: the contagem port and its counters SHALL be absent, with all other behaviour identical.

Structure
REQ-031 Shared package demux_pkg SHALL hold: NUM_CANAIS=4, DESTINO_LARGURA=2, the channel state type (VAZIO, CHEIO), and the counter width 8.
REQ-032 Sub-module demux_canal SHALL implement one channel buffer, plus its counter when enabled; the top instantiates it four times plus the destino decode.

Verification
REQ-033 Reset test: assert reset mid-stream with channel 2 CHEIO -> saida_valida=0000 and saida=0 immediately, without a clock edge.
REQ-034 Basic route test: entrada=2'b11, destino=1, all saida_pronta=0 -> next cycle saida_valida=0010 and saida[1]=11; a second word to channel 1 sees entrada_pronta=0.
REQ-035 Back-to-back test: saida_pronta[3]=1 held, words 0,1,2,3 sent to destino=3 on consecutive cycles -> entrada_pronta stays 1 and saida[3] shows 0,1,2,3 on consecutive cycles.
REQ-036 Independence test: channel 0 full and stalled; a word 2'b10 to destino=2 -> accepted, saida[2]=10 next cycle, and saida[0] unchanged.
REQ-037 Simultaneous drain/fill test: channel 1 CHEIO with 01, saida_pronta[1]=1 and entrada=10 to destino=1 -> next cycle saida[1]=10 and saida_valida[1]=1.
REQ-038 Counter test (DEMUX_CONTADOR_EN): 257 deliveries on channel 0 -> contagem[0]=1, and the other channel counters stay 0.
